// File: rtl/doc_hw_monitor_seq_pkg.sv
// Shared constants, command field layout and sequencer state type for the
// voltage/temperature monitor sequencer.
package doc_hw_pkg_hw;

    localparam int unsigned DEF_NO_CHANNELS      = 8;
    localparam int unsigned DEF_NO_TEMP_CHANNELS = 4;
    localparam int unsigned DEF_VOLT_W           = 32;
    localparam int unsigned DEF_TEMP_W           = 8;
    localparam int unsigned DEF_DEBOUNCE         = 3;
    localparam int unsigned DEF_TIMEOUT          = 1024;

    localparam int unsigned CMD_TEMP_BIT = 31;
    localparam int unsigned CMD_CH_LSB   = 0;
    localparam int unsigned CMD_CH_W     = 5;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitRsp,
        StUpdate
    } state_e;

endpackage

// File: rtl/doc_hw_monitor_seq_if.sv
// Avalon-ST command/response pair between the monitor sequencer (master)
// and the sensor IP (slave).
interface doc_hw_monitor_seq_if;

    logic        command_ready;
    logic        command_valid;
    logic [31:0] command_data;
    logic        command_startofpacket;
    logic        command_endofpacket;
    logic        response_ready;
    logic        response_valid;
    logic [31:0] response_data;
    logic        response_startofpacket;
    logic        response_endofpacket;

    modport master (
        input  command_ready,
        output command_valid,
        output command_data,
        output command_startofpacket,
        output command_endofpacket,
        output response_ready,
        input  response_valid,
        input  response_data,
        input  response_startofpacket,
        input  response_endofpacket
    );

    modport slave (
        output command_ready,
        input  command_valid,
        input  command_data,
        input  command_startofpacket,
        input  command_endofpacket,
        input  response_ready,
        output response_valid,
        output response_data,
        output response_startofpacket,
        output response_endofpacket
    );

endinterface

// File: rtl/doc_hw_monitor_seq_chan_check.sv
// Per-channel threshold check with saturating N-sample debounce; a missing
// sample (valid_i low) counts as out of range.
module doc_hw_chan_check #(
    parameter int unsigned P_W        = 8,
    parameter bit          P_SIGNED   = 1'b0,
    parameter int unsigned P_DEBOUNCE = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           upd_i,
    input  logic           valid_i,
    input  logic           clr_i,
    input  logic [P_W-1:0] sample_i,
    input  logic [P_W-1:0] lo_i,
    input  logic [P_W-1:0] hi_i,
    output logic           fault_o
);

    localparam int unsigned      CNT_W   = $clog2(P_DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(P_DEBOUNCE);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;
    logic             in_range;

    always_comb begin
        if (P_SIGNED) begin
            in_range = ($signed(sample_i) >= $signed(lo_i)) && ($signed(sample_i) <= $signed(hi_i));
        end else begin
            in_range = (sample_i >= lo_i) && (sample_i <= hi_i);
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        fault_d = fault_q;
        if (clr_i) begin
            cnt_d   = '0;
            fault_d = 1'b0;
        end else if (upd_i) begin
            if (valid_i && in_range) begin
                cnt_d   = '0;
                fault_d = 1'b0;
            end else begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                fault_d = (cnt_d == CNT_MAX);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign fault_o = fault_q;

endmodule

// File: rtl/doc_hw_monitor_seq.sv
// Round-robin voltage/temperature monitor: issues one conversion per enabled
// channel, range-checks each result and tracks lost responses.
module doc_hw_monitor_seq
    import doc_hw_pkg_hw::*;
#(
    parameter int unsigned P_NO_CHANNELS      = DEF_NO_CHANNELS,
    parameter int unsigned P_NO_TEMP_CHANNELS = DEF_NO_TEMP_CHANNELS,
    parameter int unsigned P_VOLT_W           = DEF_VOLT_W,
    parameter int unsigned P_TEMP_W           = DEF_TEMP_W,
    parameter int unsigned P_DEBOUNCE         = DEF_DEBOUNCE,
    parameter int unsigned P_TIMEOUT          = DEF_TIMEOUT
) (
    input  logic                                               clk,
    input  logic                                               reset,
    doc_hw_monitor_seq_if.master                               bus,
    input  logic [P_NO_CHANNELS-1:0]                           volt_en_i,
    input  logic [P_NO_TEMP_CHANNELS-1:0]                      temp_en_i,
    input  logic [P_NO_CHANNELS-1:0][P_VOLT_W-1:0]             volt_lo_i,
    input  logic [P_NO_CHANNELS-1:0][P_VOLT_W-1:0]             volt_hi_i,
    input  logic [P_NO_TEMP_CHANNELS-1:0][P_TEMP_W-1:0]        temp_lo_i,
    input  logic [P_NO_TEMP_CHANNELS-1:0][P_TEMP_W-1:0]        temp_hi_i,
    output logic [P_NO_CHANNELS-1:0][P_VOLT_W-1:0]             voltage_collection,
    output logic [P_NO_TEMP_CHANNELS-1:0][P_TEMP_W-1:0]        temperature_collection,
    output logic [P_NO_CHANNELS-1:0]                           volt_fault_o,
    output logic [P_NO_TEMP_CHANNELS-1:0]                      temp_fault_o,
    output logic                                               timeout_fault_o,
    output logic                                               voltage_good,
    output logic                                               temperature_good,
    output logic [15:0]                                        sweep_count_o
);

    localparam int unsigned NCH   = P_NO_CHANNELS + P_NO_TEMP_CHANNELS;
    localparam int unsigned PW    = $clog2(NCH);
    localparam int unsigned TMR_W = $clog2(P_TIMEOUT);

    state_e                          state_q, state_d;
    logic [PW-1:0]                   pos_q, pos_d;
    logic [P_NO_CHANNELS-1:0]        ven_q, ven_d;
    logic [P_NO_TEMP_CHANNELS-1:0]   ten_q, ten_d;
    logic [TMR_W-1:0]                timer_q, timer_d;
    logic [15:0]                     sweep_q, sweep_d;
    logic                            rdy_q, timeout_q, timeout_d, first_q, first_d;
    logic                            vgood_q, vgood_d, tgood_q, tgood_d;

    logic            eop_hit, expire, strobe, wrap;
    logic            nxt_found, first_found, is_temp;
    logic [PW-1:0]   nxt_pos, first_pos, ch_idx;
    logic [NCH-1:0]  en_all, en_in;
    logic [31:0]     cmd_data;
    logic            unused_sop;

    assign en_all  = {ten_q, ven_q};
    assign en_in   = {temp_en_i, volt_en_i};
    assign eop_hit = (state_q == StWaitRsp) && rdy_q && bus.response_valid
                     && bus.response_endofpacket;
    // A response landing in the expiry cycle wins over the timeout.
    assign expire  = (state_q == StWaitRsp) && !eop_hit && (timer_q == TMR_W'(P_TIMEOUT - 1));
    assign strobe  = eop_hit || expire;

    // Channel positions: voltages 0..NV-1, then temperatures NV..NCH-1.
    always_comb begin
        nxt_found   = 1'b0;
        nxt_pos     = '0;
        first_found = |en_in;
        first_pos   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (en_all[i] && (PW'(i) > pos_q)) begin
                nxt_found = 1'b1;
                nxt_pos   = PW'(i);
            end
            if (en_in[i]) first_pos = PW'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        ven_d     = ven_q;
        ten_d     = ten_q;
        timer_d   = timer_q;
        sweep_d   = sweep_q;
        first_d   = first_q;
        vgood_d   = vgood_q;
        tgood_d   = tgood_q;
        timeout_d = timeout_q | expire;
        wrap      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (first_found) begin
                    ven_d   = volt_en_i;
                    ten_d   = temp_en_i;
                    pos_d   = first_pos;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (bus.command_ready) begin
                    timer_d = '0;
                    state_d = StWaitRsp;
                end
            end
            StWaitRsp: begin
                timer_d = timer_q + TMR_W'(1);
                if (strobe) state_d = StUpdate;
            end
            StUpdate: begin
                if (nxt_found) begin
                    pos_d   = nxt_pos;
                    state_d = StIssue;
                end else begin
                    wrap    = 1'b1;
                    sweep_d = sweep_q + 16'd1;
                    first_d = 1'b1;
                    ven_d   = volt_en_i;
                    ten_d   = temp_en_i;
                    pos_d   = first_pos;
                    state_d = first_found ? StIssue : StIdle;
                end
                vgood_d = first_d && !timeout_q && (|ven_d) && !(|(volt_fault_o & ven_d));
                tgood_d = first_d && !timeout_q && (|ten_d) && !(|(temp_fault_o & ten_d));
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            pos_q     <= '0;
            ven_q     <= '0;
            ten_q     <= '0;
            timer_q   <= '0;
            sweep_q   <= '0;
            rdy_q     <= 1'b0;
            timeout_q <= 1'b0;
            first_q   <= 1'b0;
            vgood_q   <= 1'b0;
            tgood_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            ven_q     <= ven_d;
            ten_q     <= ten_d;
            timer_q   <= timer_d;
            sweep_q   <= sweep_d;
            rdy_q     <= 1'b1;
            timeout_q <= timeout_d;
            first_q   <= first_d;
            vgood_q   <= vgood_d;
            tgood_q   <= tgood_d;
        end
    end

    assign is_temp = (pos_q >= PW'(P_NO_CHANNELS));
    assign ch_idx  = is_temp ? (pos_q - PW'(P_NO_CHANNELS)) : pos_q;

    always_comb begin
        cmd_data                           = '0;
        cmd_data[CMD_TEMP_BIT]             = is_temp;
        cmd_data[CMD_CH_LSB +: CMD_CH_W]   = CMD_CH_W'(ch_idx);
    end

    assign bus.command_valid         = (state_q == StIssue);
    assign bus.command_data          = cmd_data;
    assign bus.command_startofpacket = bus.command_valid;
    assign bus.command_endofpacket   = bus.command_valid;
    assign bus.response_ready        = rdy_q;
    assign unused_sop                = bus.response_startofpacket;

    for (genvar g = 0; g < P_NO_CHANNELS; g++) begin : g_volt
        logic                hit;
        logic [P_VOLT_W-1:0] coll_q;
        assign hit = (pos_q == PW'(g));
        always_ff @(posedge clk) begin
            if (!reset) coll_q <= '0;
            else if (eop_hit && hit) coll_q <= bus.response_data[P_VOLT_W-1:0];
        end
        assign voltage_collection[g] = coll_q;
        doc_hw_chan_check #(
            .P_W        (P_VOLT_W),
            .P_SIGNED   (1'b0),
            .P_DEBOUNCE (P_DEBOUNCE)
        ) u_chk (
            .clk      (clk),
            .reset    (reset),
            .upd_i    (strobe && hit),
            .valid_i  (eop_hit),
            .clr_i    (wrap && !volt_en_i[g]),
            .sample_i (bus.response_data[P_VOLT_W-1:0]),
            .lo_i     (volt_lo_i[g]),
            .hi_i     (volt_hi_i[g]),
            .fault_o  (volt_fault_o[g])
        );
    end

    for (genvar g = 0; g < P_NO_TEMP_CHANNELS; g++) begin : g_temp
        logic                hit;
        logic [P_TEMP_W-1:0] coll_q;
        assign hit = (pos_q == PW'(P_NO_CHANNELS + g));
        always_ff @(posedge clk) begin
            if (!reset) coll_q <= '0;
            else if (eop_hit && hit) coll_q <= bus.response_data[P_TEMP_W-1:0];
        end
        assign temperature_collection[g] = coll_q;
        doc_hw_chan_check #(
            .P_W        (P_TEMP_W),
            .P_SIGNED   (1'b1),
            .P_DEBOUNCE (P_DEBOUNCE)
        ) u_chk (
            .clk      (clk),
            .reset    (reset),
            .upd_i    (strobe && hit),
            .valid_i  (eop_hit),
            .clr_i    (wrap && !temp_en_i[g]),
            .sample_i (bus.response_data[P_TEMP_W-1:0]),
            .lo_i     (temp_lo_i[g]),
            .hi_i     (temp_hi_i[g]),
            .fault_o  (temp_fault_o[g])
        );
    end

    assign timeout_fault_o  = timeout_q;
    assign voltage_good     = vgood_q;
    assign temperature_good = tgood_q;
    assign sweep_count_o    = sweep_q;

endmodule

// File: tb/tb_doc_hw_monitor_seq.sv
// Directed bench for doc_hw_monitor_seq: acts as the sensor and checks every
// transaction against a queue-based sweep model.
module tb_doc_hw_monitor_seq;

    localparam int NV = 8;
    localparam int NT = 4;
    localparam int DB = 3;
    localparam int TO = 16;
    localparam logic [31:0] V_LO = 32'h80;
    localparam logic [31:0] V_HI = 32'h200;
    localparam int T_LO = -10;
    localparam int T_HI = 85;

    logic clk = 1'b0;
    logic reset;
    logic [NV-1:0] volt_en;
    logic [NT-1:0] temp_en;
    logic [NV-1:0][31:0] volt_lo, volt_hi, voltage_collection;
    logic [NT-1:0][7:0]  temp_lo, temp_hi, temperature_collection;
    logic [NV-1:0] volt_fault;
    logic [NT-1:0] temp_fault;
    logic timeout_fault, voltage_good, temperature_good;
    logic [15:0] sweep_count;

    doc_hw_monitor_seq_if bus ();

    doc_hw_monitor_seq #(
        .P_NO_CHANNELS      (NV),
        .P_NO_TEMP_CHANNELS (NT),
        .P_VOLT_W           (32),
        .P_TEMP_W           (8),
        .P_DEBOUNCE         (DB),
        .P_TIMEOUT          (TO)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .bus                    (bus),
        .volt_en_i              (volt_en),
        .temp_en_i              (temp_en),
        .volt_lo_i              (volt_lo),
        .volt_hi_i              (volt_hi),
        .temp_lo_i              (temp_lo),
        .temp_hi_i              (temp_hi),
        .voltage_collection     (voltage_collection),
        .temperature_collection (temperature_collection),
        .volt_fault_o           (volt_fault),
        .temp_fault_o           (temp_fault),
        .timeout_fault_o        (timeout_fault),
        .voltage_good           (voltage_good),
        .temperature_good       (temperature_good),
        .sweep_count_o          (sweep_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: channel ids 0..NV-1 are voltages, NV..NV+NT-1 temperatures.
    logic [31:0] m_vcoll [NV];
    logic [7:0]  m_tcoll [NT];
    int          m_cnt   [NV+NT];
    bit          m_flt   [NV+NT];
    logic [NV-1:0] m_ven;
    logic [NT-1:0] m_ten;
    bit  m_first, m_to, m_vgood, m_tgood;
    int  m_sweep;
    int  m_queue [$];

    logic [31:0] v2_val, t1_val, t3_val;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_build();
        m_ven = volt_en;
        m_ten = temp_en;
        m_queue.delete();
        for (int i = 0; i < NV; i++) if (m_ven[i]) m_queue.push_back(i);
        for (int i = 0; i < NT; i++) if (m_ten[i]) m_queue.push_back(NV + i);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NV; i++) m_vcoll[i] = '0;
        for (int i = 0; i < NT; i++) m_tcoll[i] = '0;
        for (int i = 0; i < NV + NT; i++) begin
            m_cnt[i] = 0;
            m_flt[i] = 1'b0;
        end
        m_first = 1'b0;
        m_to    = 1'b0;
        m_vgood = 1'b0;
        m_tgood = 1'b0;
        m_sweep = 0;
        model_build();
    endfunction

    function automatic bit sample_ok(input int ch, input logic [31:0] d);
        logic [7:0] t8;
        int s;
        if (ch < NV) return (d >= V_LO) && (d <= V_HI);
        t8 = d[7:0];
        s  = $signed(t8);
        return (s >= T_LO) && (s <= T_HI);
    endfunction

    function automatic void model_sample(input int ch, input logic [31:0] d, input bit lost);
        if (!lost) begin
            if (ch < NV) m_vcoll[ch] = d;
            else m_tcoll[ch - NV] = d[7:0];
        end
        if (!lost && sample_ok(ch, d)) begin
            m_cnt[ch] = 0;
            m_flt[ch] = 1'b0;
        end else begin
            m_cnt[ch] = (m_cnt[ch] < DB) ? m_cnt[ch] + 1 : DB;
            m_flt[ch] = (m_cnt[ch] == DB);
        end
    endfunction

    function automatic void model_advance();
        bit vbad, tbad;
        if (m_queue.size() > 0) void'(m_queue.pop_front());
        if (m_queue.size() == 0) begin
            m_sweep = (m_sweep + 1) % 65536;
            m_first = 1'b1;
            model_build();
            for (int i = 0; i < NV; i++) if (!m_ven[i]) begin m_cnt[i] = 0; m_flt[i] = 1'b0; end
            for (int i = 0; i < NT; i++) if (!m_ten[i]) begin m_cnt[NV+i] = 0; m_flt[NV+i] = 1'b0; end
        end
        vbad = 1'b0;
        tbad = 1'b0;
        for (int i = 0; i < NV; i++) if (m_ven[i] && m_flt[i]) vbad = 1'b1;
        for (int i = 0; i < NT; i++) if (m_ten[i] && m_flt[NV+i]) tbad = 1'b1;
        m_vgood = m_first && !m_to && (m_ven != 0) && !vbad;
        m_tgood = m_first && !m_to && (m_ten != 0) && !tbad;
    endfunction

    task automatic check_state(input string tag);
        logic [NV-1:0] ev;
        logic [NT-1:0] et;
        for (int i = 0; i < NV; i++) begin
            ev[i] = m_flt[i];
            chk($sformatf("%s vcoll[%0d]", tag, i), voltage_collection[i], m_vcoll[i]);
        end
        for (int i = 0; i < NT; i++) begin
            et[i] = m_flt[NV+i];
            chk($sformatf("%s tcoll[%0d]", tag, i), temperature_collection[i], m_tcoll[i]);
        end
        chk({tag, " volt_fault"}, volt_fault, ev);
        chk({tag, " temp_fault"}, temp_fault, et);
        chk({tag, " timeout"}, timeout_fault, m_to);
        chk({tag, " vgood"}, voltage_good, m_vgood);
        chk({tag, " tgood"}, temperature_good, m_tgood);
        chk({tag, " sweep"}, sweep_count, m_sweep[15:0]);
    endtask

    function automatic logic [31:0] exp_cmd(input int ch);
        logic [31:0] c;
        c = '0;
        if (ch >= NV) begin
            c[31]  = 1'b1;
            c[4:0] = 5'(ch - NV);
        end else begin
            c[4:0] = 5'(ch);
        end
        return c;
    endfunction

    function automatic logic [31:0] pick(input int ch);
        if (ch == 2) return v2_val;
        if (ch == NV + 1) return t1_val;
        if (ch == NV + 3) return t3_val;
        return (ch < NV) ? 32'h100 : 32'd25;
    endfunction

    task automatic wait_cmd(output bit ok);
        int k;
        k = 0;
        while (bus.command_valid !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        ok = (bus.command_valid === 1'b1);
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL cmd_wait: got command_valid=%b, expected 1 within 40 cycles",
                     bus.command_valid);
        end
    endtask

    // One command/response exchange, checked at handshake, T+1 and T+2.
    task automatic txn(input int hold, input bit withhold);
        int ch;
        bit ok;
        logic [31:0] d, ec;
        ch = (m_queue.size() > 0) ? m_queue[0] : -1;
        d  = pick(ch);
        ec = exp_cmd(ch);
        wait_cmd(ok);
        if (!ok) begin
            model_advance();
            return;
        end
        chk("cmd_data", bus.command_data, ec);
        chk("cmd_sop_eop", {bus.command_startofpacket, bus.command_endofpacket}, 2'b11);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", bus.command_valid, 1'b1);
            chk("hold_data", bus.command_data, ec);
        end
        bus.command_ready = 1'b1;
        @(negedge clk);
        bus.command_ready = 1'b0;
        chk("cmd_drop", bus.command_valid, 1'b0);
        if (withhold) begin
            for (int i = 0; i < TO; i++) begin
                chk("to_pending", timeout_fault, 1'b0);
                @(negedge clk);
            end
            m_to = 1'b1;
            model_sample(ch, '0, 1'b1);
            check_state("timeout");
        end else begin
            bus.response_valid         = 1'b1;
            bus.response_startofpacket = 1'b1;
            bus.response_endofpacket   = 1'b0;
            bus.response_data          = 32'hDEAD_BEEF;
            @(negedge clk);
            bus.response_startofpacket = 1'b0;
            bus.response_endofpacket   = 1'b1;
            bus.response_data          = d;
            @(negedge clk);
            bus.response_valid       = 1'b0;
            bus.response_endofpacket = 1'b0;
            model_sample(ch, d, 1'b0);
            check_state("sample");
        end
        @(negedge clk);
        model_advance();
        check_state("advance");
        chk("next_cmd", bus.command_valid, m_queue.size() > 0);
    endtask

    task automatic run_sweep(input int withhold_ch, input int hold_ch);
        int n;
        n = m_queue.size();
        for (int i = 0; i < n; i++) begin
            txn((m_queue.size() > 0 && m_queue[0] == hold_ch) ? 5 : 0,
                m_queue.size() > 0 && m_queue[0] == withhold_ch);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        reset                      = 1'b0;
        bus.command_ready          = 1'b0;
        bus.response_valid         = 1'b0;
        bus.response_data          = '0;
        bus.response_startofpacket = 1'b0;
        bus.response_endofpacket   = 1'b0;
        volt_en = '1;
        temp_en = '1;
        for (int i = 0; i < NV; i++) begin
            volt_lo[i] = V_LO;
            volt_hi[i] = V_HI;
        end
        for (int i = 0; i < NT; i++) begin
            temp_lo[i] = 8'(T_LO);
            temp_hi[i] = 8'(T_HI);
        end
        v2_val = 32'h100;
        t1_val = 32'd25;
        t3_val = 32'd25;

        repeat (3) @(negedge clk);
        model_reset();
        check_state("reset");
        chk("reset cmd_valid", bus.command_valid, 1'b0);
        chk("reset rsp_ready", bus.response_ready, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("rsp_ready after reset", bus.response_ready, 1'b1);

        // Sweep 1: everything in range.
        run_sweep(-1, -1);
        chk("lit sweep1 vgood", voltage_good, 1'b1);
        chk("lit sweep1 tgood", temperature_good, 1'b1);
        chk("lit sweep1 count", sweep_count, 16'd1);
        chk("lit sweep1 vcoll3", voltage_collection[3], 32'h100);
        chk("lit sweep1 tcoll2", temperature_collection[2], 8'd25);

        // Sweeps 2-4: v2 high, t1 = -20 (out), t3 = -5 (in range only if signed).
        v2_val = 32'h300;
        t1_val = 32'h0000_00EC;
        t3_val = 32'h0000_00FB;
        run_sweep(-1, -1);
        run_sweep(-1, -1);
        chk("lit sweep3 vfault", volt_fault, 8'h00);
        chk("lit sweep3 tfault", temp_fault, 4'h0);
        run_sweep(-1, -1);
        chk("lit sweep4 vfault", volt_fault, 8'h04);
        chk("lit sweep4 tfault", temp_fault, 4'h2);
        chk("lit sweep4 vgood", voltage_good, 1'b0);
        chk("lit sweep4 tcoll3", temperature_collection[3], 8'hFB);

        // Sweep 5: recovery.
        v2_val = 32'h150;
        t1_val = 32'd25;
        t3_val = 32'd25;
        run_sweep(-1, -1);
        chk("lit sweep5 vfault", volt_fault, 8'h00);
        chk("lit sweep5 vgood", voltage_good, 1'b1);
        chk("lit sweep5 tgood", temperature_good, 1'b1);

        // Sweep 6: lost response on v0, then mask change pending until wrap.
        txn(0, 1'b1);
        chk("lit timeout", timeout_fault, 1'b1);
        chk("lit timeout vcoll0", voltage_collection[0], 32'h100);
        volt_en = 8'b0000_0101;
        temp_en = 4'b0000;
        run_sweep(-1, -1);
        run_sweep(-1, 0);
        run_sweep(-1, -1);
        chk("lit sweep8 count", sweep_count, 16'd8);
        chk("lit sweep8 timeout sticky", timeout_fault, 1'b1);
        chk("lit sweep8 tgood empty", temperature_good, 1'b0);

        // Reset while waiting for a response; the late response must be dropped.
        wait_cmd(ok);
        if (ok) begin
            chk("rst cmd_data", bus.command_data, 32'h0);
            bus.command_ready = 1'b1;
            @(negedge clk);
            bus.command_ready = 1'b0;
            @(negedge clk);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("in reset cmd_valid", bus.command_valid, 1'b0);
        chk("in reset rsp_ready", bus.response_ready, 1'b0);
        @(negedge clk);
        reset                    = 1'b1;
        bus.response_valid       = 1'b1;
        bus.response_endofpacket = 1'b1;
        bus.response_data        = 32'h1FF;
        repeat (2) @(negedge clk);
        bus.response_valid       = 1'b0;
        bus.response_endofpacket = 1'b0;
        model_reset();
        check_state("post_reset");
        txn(0, 1'b0);
        chk("lit post_reset vcoll2", voltage_collection[2], 32'h0);
        chk("lit post_reset count", sweep_count, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
